pam4_channel_tx: RTL and testbench

Transmit-side stimulus source for the CMA equalizer chain. Generates a PRBS-9 bit stream, Gray-maps it to PAM4 symbols and passes them through a programmable ISI channel FIR. It emits fixed-point samples in the equalizer's input format (S(18,15)) through a valid/ready handshake. It replaces the precomputed channel-symbol file as the equalizer's source in on-chip loopback.

---
 rtl/pam4_channel_tx.sv | 135 +++++++++++++
 tb/tb_pam4_channel_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pam4_channel_tx.sv
// pam4_channel_tx
//   PRBS-9 -> Gray-coded PAM4 -> programmable ISI channel FIR, producing
//   S(NB_OUT,NBF_OUT) samples for the CMA equalizer in on-chip loopback.
//
// Ports
//   i_clock       clock, all state on rising edge
//   i_reset       asynchronous active-low reset
//   i_en          global enable; 0 freezes the stream
//   i_ready       downstream accepts o_sample
//   i_coeff_we    channel coefficient write strobe (independent of i_en)
//   i_coeff_addr  tap index; values >= CH_LEN are ignored
//   i_coeff_data  coefficient, S(NB_CH,NBF_CH)
//   o_sample      channel output, S(NB_OUT,NBF_OUT), floor + saturate
//   o_symbol      transmitted PAM4 level {-3,-1,+1,+3}, aligned with o_sample
//   o_valid       sticky after the first advance until reset

// One channel tap: coefficient S(NB_CH,NBF_CH) times symbol S(3,2).
module pam4_ch_tap #(
    parameter int NB_CH = 16
) (
    input  logic signed [NB_CH-1:0] coeff,
    input  logic signed [2:0]       sym,
    output logic signed [NB_CH+2:0] prod
);
    assign prod = (NB_CH+3)'(coeff) * (NB_CH+3)'(sym);
endmodule

module pam4_channel_tx #(
    parameter int         NB_OUT    = 18,
    parameter int         NBF_OUT   = 15,
    parameter int         CH_LEN    = 5,
    parameter int         NB_CH     = 16,
    parameter int         NBF_CH    = 14,
    parameter logic [8:0] PRBS_SEED = 9'h001,
    localparam int        AW        = (CH_LEN > 1) ? $clog2(CH_LEN) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_en,
    input  logic                     i_ready,
    input  logic                     i_coeff_we,
    input  logic [AW-1:0]            i_coeff_addr,
    input  logic signed [NB_CH-1:0]  i_coeff_data,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic signed [2:0]        o_symbol,
    output logic                     o_valid
);
    localparam int NB_PROD = NB_CH + 3;
    localparam int NB_ACC  = NB_PROD + AW;           // guard bits for the tap sum
    localparam int SH      = NBF_CH + 2 - NBF_OUT;   // LSBs dropped by floor
    localparam logic [8:0] SEED = (PRBS_SEED == 9'h000) ? 9'h1FF : PRBS_SEED;
    localparam logic [NB_CH-1:0] COEF_ONE = NB_CH'(1) << NBF_CH;
    localparam logic signed [NB_OUT-1:0] OUT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
    localparam logic signed [NB_OUT-1:0] OUT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};
    localparam logic signed [NB_ACC-1:0] ACC_MAX = NB_ACC'(OUT_MAX);
    localparam logic signed [NB_ACC-1:0] ACC_MIN = NB_ACC'(OUT_MIN);

    logic [8:0]                      lfsr, lfsr_s1, lfsr_s2;
    logic [1:0]                      bits;
    logic signed [2:0]               sym_new;
    logic [CH_LEN-1:0][2:0]          dly, dnx;
    logic [CH_LEN-1:0][NB_CH-1:0]    coef;
    logic [CH_LEN-1:0][NB_PROD-1:0]  prod;
    logic signed [NB_ACC-1:0]        acc, acc_sh;
    logic signed [NB_OUT-1:0]        sample_nx;
    logic                            adv;

    assign adv = i_en && (!o_valid || i_ready);

    // Two LFSR steps per symbol; the first feedback bit is the MSB.
    always_comb begin
        lfsr_s1 = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        lfsr_s2 = {lfsr_s1[7:0], lfsr_s1[8] ^ lfsr_s1[4]};
        bits    = {lfsr_s1[0], lfsr_s2[0]};
    end

    // Gray map, levels held as raw S(3,2) codes (value/4).
    always_comb begin
        case (bits)
            2'b00:   sym_new = -3'sd3;
            2'b01:   sym_new = -3'sd1;
            2'b11:   sym_new =  3'sd1;
            default: sym_new =  3'sd3;
        endcase
    end

    // The FIR sees the line as it will be after this advance.
    always_comb begin
        dnx[0] = sym_new;
        for (int k = 1; k < CH_LEN; k++) dnx[k] = dly[k-1];
    end

    for (genvar k = 0; k < CH_LEN; k++) begin : g_tap
        pam4_ch_tap #(.NB_CH(NB_CH)) u_tap (
            .coeff (coef[k]),
            .sym   (dnx[k]),
            .prod  (prod[k])
        );
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < CH_LEN; k++) acc += NB_ACC'($signed(prod[k]));
        acc_sh = acc >>> SH;
        if (acc_sh > ACC_MAX)      sample_nx = OUT_MAX;
        else if (acc_sh < ACC_MIN) sample_nx = OUT_MIN;
        else                       sample_nx = acc_sh[NB_OUT-1:0];
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lfsr     <= SEED;
            dly      <= '0;
            o_sample <= '0;
            o_symbol <= '0;
            o_valid  <= 1'b0;
        end else if (adv) begin
            lfsr     <= lfsr_s2;
            dly      <= dnx;
            o_sample <= sample_nx;
            o_symbol <= sym_new;
            o_valid  <= 1'b1;
        end
    end

    // Coefficient writes land regardless of adv; a same-cycle advance still
    // multiplies by the old value because the FIR reads the register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < CH_LEN; k++) coef[k] <= (k == 0) ? COEF_ONE : '0;
        end else if (i_coeff_we && (int'(i_coeff_addr) < CH_LEN)) begin
            coef[i_coeff_addr] <= i_coeff_data;
        end
    end
endmodule

// File: tb/tb_pam4_channel_tx.sv
module tb_pam4_channel_tx;
    localparam int CH_LEN = 5;
    localparam logic [8:0] SEED = 9'h001;
    localparam int NBITS = 9 + 2*4096;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0, rdy = 1'b0, we = 1'b0;
    logic [2:0]         addr = '0;
    logic signed [15:0] data = '0;
    logic signed [17:0] o_sample;
    logic signed [2:0]  o_symbol;
    logic               o_valid;

    always #5 clk = ~clk;

    pam4_channel_tx dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_en         (en),
        .i_ready      (rdy),
        .i_coeff_we   (we),
        .i_coeff_addr (addr),
        .i_coeff_data (data),
        .o_sample     (o_sample),
        .o_symbol     (o_symbol),
        .o_valid      (o_valid)
    );

    typedef struct { int sym; int smp; } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;

    // Reference model: PRBS as a bit recurrence b[n] = b[n-9] ^ b[n-5],
    // symbol i built from bits 9+2i (MSB) and 10+2i.
    bit   prbs[NBITS];
    int   gray[4] = '{-3, -1, 3, 1};
    int   m_coef[CH_LEN];
    int   m_hist[$];
    int   m_idx;
    bit   m_valid;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_coef = '{16384, 0, 0, 0, 0};
        m_hist.delete();
        m_idx = 0;
        m_valid = 0;
        exp_q.delete();
    endtask

    task automatic drive_model(bit e, bit r, bit w, logic [2:0] a, logic [15:0] d);
        int     s;
        longint sum;
        en = e; rdy = r; we = w; addr = a; data = d;
        if (e && (!m_valid || r)) begin
            s = gray[2*int'(prbs[9+2*m_idx]) + int'(prbs[10+2*m_idx])];
            m_idx++;
            m_hist.push_front(s);
            if (m_hist.size() > CH_LEN) void'(m_hist.pop_back());
            sum = 0;
            foreach (m_hist[k]) sum += longint'(m_coef[k]) * m_hist[k];
            sum = sum >>> 1;  // units 2^-16 -> 2^-15, floor
            if (sum > 131071) sum = 131071;
            if (sum < -131072) sum = -131072;
            exp_q.push_back('{s, int'(sum)});
            m_valid = 1;
        end
        if (w && a < CH_LEN) m_coef[a] = int'($signed(d));
    endtask

    task automatic step(bit e, bit r, bit w, logic [2:0] a, logic [15:0] d);
        @(posedge clk); #2;
        drive_model(e, r, w, a, d);
    endtask

    task automatic do_reset(string tag);
        @(posedge clk); #3;
        rst_n = 1'b0; en = 1'b0; we = 1'b0;
        #1;
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_sample"}, int'(o_sample), 0);
        chk({tag, "_symbol"}, int'(o_symbol), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // First output after reset: seed 001 gives bits 00 -> -3 / -0.75.
    task automatic first_out(string tag);
        step(1, 1, 0, 3'd0, 16'd0);
        @(posedge clk); #1;
        chk({tag, "_first_symbol"}, int'(o_symbol), -3);
        chk({tag, "_first_sample"}, int'(o_sample), -24576);
        #1 drive_model(1, 1, 0, 3'd0, 16'd0);
    endtask

    // Monitor: decide at the negedge whether the next edge advances, then
    // check just after the edge: pop on advance, otherwise expect a hold.
    bit   mon_live, mon_pend;
    int   h_sym, h_smp, h_vld;
    exp_t mon_e;
    always begin
        @(negedge clk);
        mon_live = rst_n;
        mon_pend = en && (!o_valid || rdy);
        h_sym = int'(o_symbol); h_smp = int'(o_sample); h_vld = int'(o_valid);
        @(posedge clk); #1;
        if (mon_live && rst_n) begin
            if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("symbol", int'(o_symbol), mon_e.sym);
                    chk("sample", int'(o_sample), mon_e.smp);
                    chk("valid", int'(o_valid), 1);
                end
            end else begin
                chk("hold_symbol", int'(o_symbol), h_sym);
                chk("hold_sample", int'(o_sample), h_smp);
                chk("hold_valid", int'(o_valid), h_vld);
            end
        end
    end

    initial begin
        logic [8:0] sv;
        sv = SEED;
        for (int j = 0; j < 9; j++) prbs[j] = sv[8-j];
        for (int n = 9; n < NBITS; n++) prbs[n] = prbs[n-9] ^ prbs[n-5];
        model_reset();

        do_reset("rst0");
        first_out("rst0");

        // Identity channel, two PRBS periods, with a 5-cycle stall mid-way.
        for (int i = 0; i < 1022; i++) begin
            if (i == 500) for (int j = 0; j < 5; j++) step(1, 0, 0, 3'd0, 16'd0);
            step(1, 1, 0, 3'd0, 16'd0);
        end

        // Write c[0]=0 on an advancing cycle, then an out-of-range write.
        step(1, 1, 1, 3'd0, 16'd0);
        step(1, 1, 1, 3'd5, 16'h7FFF);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 3'd0, 16'd0);

        // ISI channel {1.0, 0.5, -0.25, 0, 0} under random enable/backpressure.
        step(0, 1, 1, 3'd0, 16'd16384);
        step(0, 1, 1, 3'd1, 16'd8192);
        step(0, 1, 1, 3'd2, 16'hF000);
        step(0, 1, 1, 3'd3, 16'd0);
        step(0, 1, 1, 3'd4, 16'd0);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 0, 3'd0, 16'd0);

        // Saturation: every tap at max positive.
        for (int k = 0; k < CH_LEN; k++) step(0, 1, 1, 3'(k), 16'h7FFF);
        for (int i = 0; i < 200; i++) step(1, $urandom_range(0, 4) != 0, 0, 3'd0, 16'd0);

        // Random coefficient writes (including ignored addresses) mid-stream.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 16'($urandom));

        // Reset mid-stream: restart from seed with identity channel.
        do_reset("rst1");
        first_out("rst1");
        for (int i = 0; i < 50; i++)
            step(1, $urandom_range(0, 3) != 0, 0, 3'd0, 16'd0);

        for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd0, 16'd0);
        @(posedge clk); #3;
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
